jtpang_objdma: RTL and testbench



---
 rtl/jtpang_objdma.sv | 111 +++++++++++
 tb/tb_jtpang_objdma.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_objdma.sv
// Object-table DMA: on a dma_go edge, take the Z80 bus and copy 2^AW bytes of
// sprite attributes from video RAM into the object line-engine buffer.
module jtpang_objdma #(
    parameter int AW  = 9,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          dma_go,
    output logic          busrq_n,
    input  logic          busak_n,
    output logic [AW-1:0] src_addr,
    output logic          src_cs,
    input  logic [7:0]    src_dout,
    output logic [AW-1:0] obj_addr,
    output logic [7:0]    obj_din,
    output logic          obj_we,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, REQ, COPY, REL} state_t;

    localparam logic [AW:0]    LAST = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0]    ONE  = (AW+1)'(1);
    localparam logic [LAT-1:0] VIN  = LAT'(1);

    state_t         state_q;
    logic           go_l_q, pend_q, pend_d;
    logic           busrq_n_q, busy_q, src_cs_q, obj_we_q;
    logic [AW:0]    cnt_q, wcnt_q;
    logic [LAT-1:0] vld_pipe_q;
    logic [AW-1:0]  obj_addr_q;
    logic [7:0]     obj_din_q;
    logic           rise, take, wr;

    assign rise   = dma_go & ~go_l_q;
    assign take   = cen & pend_q & ((state_q == IDLE) | (state_q == REL));
    // A new edge in the same clk as the hand-off is a distinct request, so set wins.
    assign pend_d = (pend_q & ~take) | rise;
    // vld_pipe_q marks which in-flight reads carry a fresh address; the oldest one lands now.
    assign wr     = cen & (state_q == COPY) & ~busak_n & vld_pipe_q[LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            go_l_q     <= 1'b0;
            pend_q     <= 1'b0;
            busrq_n_q  <= 1'b1;
            busy_q     <= 1'b0;
            src_cs_q   <= 1'b0;
            obj_we_q   <= 1'b0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            vld_pipe_q <= '0;
            obj_addr_q <= '0;
            obj_din_q  <= '0;
        end else begin
            go_l_q   <= dma_go;
            pend_q   <= pend_d;
            obj_we_q <= wr;
            if (cen) begin
                case (state_q)
                    IDLE: if (pend_q) begin
                        state_q   <= REQ;
                        busrq_n_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                    REQ: if (!busak_n) begin
                        state_q    <= COPY;
                        cnt_q      <= '0;
                        wcnt_q     <= '0;
                        vld_pipe_q <= '0;
                        src_cs_q   <= 1'b1;
                    end
                    COPY: if (busak_n) begin
                        // Bus lost: drop in-flight reads and refetch from the write pointer.
                        cnt_q      <= wcnt_q;
                        vld_pipe_q <= '0;
                    end else begin
                        if (cnt_q != LAST) cnt_q <= cnt_q + ONE;
                        vld_pipe_q <= (vld_pipe_q << 1) | VIN;
                        if (vld_pipe_q[LAT-1]) begin
                            obj_addr_q <= wcnt_q[AW-1:0];
                            obj_din_q  <= src_dout;
                            wcnt_q     <= wcnt_q + ONE;
                            if (wcnt_q == LAST) begin
                                state_q   <= REL;
                                busrq_n_q <= 1'b1;
                                src_cs_q  <= 1'b0;
                            end
                        end
                    end
                    REL: begin
                        state_q   <= pend_q ? REQ : IDLE;
                        busrq_n_q <= ~pend_q;
                        busy_q    <= pend_q;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busrq_n  = busrq_n_q;
    assign busy     = busy_q;
    assign src_cs   = src_cs_q;
    assign src_addr = cnt_q[AW-1:0];
    assign obj_we   = obj_we_q;
    assign obj_addr = obj_addr_q;
    assign obj_din  = obj_din_q;
endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: LAT=1 and LAT=2 instances share stimulus; a queue of
// expected (addr,data) writes per instance is consumed by a negedge monitor.
module tb_jtpang_objdma;
    localparam int AW = 9;
    localparam int N  = 1 << AW;

    logic clk = 1'b0, rst = 1'b1, cen = 1'b0, dma_go = 1'b0, hold = 1'b0;
    logic [7:0] src_mem [N];
    int tick = 0, checks = 0, failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1 cen = ($urandom_range(0, 3) != 0);
    end
    always @(posedge clk) if (cen) tick <= tick + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen
        localparam int LT = g + 1;
        logic busrq_n, src_cs, obj_we, busy;
        logic busak_n = 1'b1;
        logic [AW-1:0] src_addr, obj_addr;
        logic [7:0] src_dout, obj_din;
        logic [7:0] pipe [LT];
        int ak_cnt = 0;
        logic t_cen = 1'b0, t_ak = 1'b1;
        bit [AW+7:0] q [$];
        bit [AW+7:0] e;
        int nw = 0, cticks = 0, last_copy = 0, hi_run = 0, last_gap = 0, ack_tick = 0;
        bit await_ack = 0, first_pend = 0, prev_rq = 1, prev_cs = 0;

        jtpang_objdma #(.AW(AW), .LAT(LT)) u_dut (
            .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go),
            .busrq_n(busrq_n), .busak_n(busak_n),
            .src_addr(src_addr), .src_cs(src_cs), .src_dout(src_dout),
            .obj_addr(obj_addr), .obj_din(obj_din), .obj_we(obj_we), .busy(busy)
        );

        // Source RAM with LT-tick read latency, plus a CPU granting the bus 2 ticks late.
        assign src_dout = pipe[LT-1];
        always @(posedge clk) begin
            t_cen <= cen;
            t_ak  <= busak_n;
            if (cen) begin
                pipe[0] <= src_mem[src_addr];
                for (int k = 1; k < LT; k++) pipe[k] <= pipe[k-1];
            end
            if (rst) begin
                ak_cnt  <= 0;
                busak_n <= 1'b1;
            end else if (cen) begin
                if (busrq_n) begin
                    ak_cnt  <= 0;
                    busak_n <= 1'b1;
                end else begin
                    if (ak_cnt < 2) ak_cnt <= ak_cnt + 1;
                    busak_n <= hold || (ak_cnt < 1);
                end
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                await_ack  = 0;
                first_pend = 0;
                cticks     = 0;
                prev_cs    = 0;
            end else begin
                if (obj_we) begin
                    nw++;
                    chk("we_on_granted_cen_tick", {t_cen, t_ak}, 2'b10);
                    if (q.size() == 0) chk("sb_extra_write", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("sb_addr", obj_addr, e[AW+7:8]);
                        chk("sb_data", obj_din, e[7:0]);
                    end
                    if (first_pend) begin
                        chk("ack_to_first_we", tick - ack_tick, LT + 1);
                        first_pend = 0;
                    end
                end
                if (prev_rq && !busrq_n) await_ack = 1;
                prev_rq = busrq_n;
                if (cen) begin
                    if (await_ack && !busrq_n && !busak_n) begin
                        ack_tick   = tick + 1;
                        await_ack  = 0;
                        first_pend = 1;
                    end
                    if (busrq_n) hi_run++;
                    else begin
                        if (hi_run > 0) last_gap = hi_run;
                        hi_run = 0;
                    end
                    if (src_cs) cticks++;
                end
                if (prev_cs && !src_cs) begin
                    last_copy = cticks;
                    cticks    = 0;
                end
                prev_cs = src_cs;
            end
        end
    end

    task automatic fill(input bit rnd);
        for (int a = 0; a < N; a++) src_mem[a] = rnd ? 8'($urandom) : (8'(a) ^ 8'h5A);
    endtask

    task automatic push_copy();
        for (int a = 0; a < N; a++) begin
            gen[0].q.push_back({a[AW-1:0], src_mem[a]});
            gen[1].q.push_back({a[AW-1:0], src_mem[a]});
        end
    endtask

    task automatic trigger();
        push_copy();
        @(negedge clk) dma_go = 1'b1;
        repeat (4) @(negedge clk);
        dma_go = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int t0 = tick;
        while (tick < t0 + n) @(negedge clk);
    endtask

    task automatic wait_nw(input string nm, input int target);
        int n = 0;
        while (gen[0].nw < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk({nm, "_timeout"}, 1, 0);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(gen[0].q.size() == 0 && gen[1].q.size() == 0 && !gen[0].busy && !gen[1].busy
                 && gen[0].busrq_n && gen[1].busrq_n) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk({nm, "_timeout"}, 1, 0);
        wait_ticks(3);
    endtask

    task automatic check_rst(input string nm);
        logic [29:0] rv = {1'b1, 29'd0};
        chk({nm, "_lat1"}, {gen[0].busrq_n, gen[0].busy, gen[0].obj_we, gen[0].src_cs,
                            gen[0].src_addr, gen[0].obj_addr, gen[0].obj_din}, rv);
        chk({nm, "_lat2"}, {gen[1].busrq_n, gen[1].busy, gen[1].obj_we, gen[1].src_cs,
                            gen[1].src_addr, gen[1].obj_addr, gen[1].obj_din}, rv);
    endtask

    initial begin
        int b0, b1, bad;
        fill(0);
        repeat (4) @(negedge clk);
        check_rst("reset_state");
        @(negedge clk) rst = 1'b0;

        // Basic copy with the address-pattern source.
        b0 = gen[0].nw; b1 = gen[1].nw;
        trigger();
        wait_idle("basic");
        chk("basic_writes_lat1", gen[0].nw - b0, N);
        chk("basic_writes_lat2", gen[1].nw - b1, N);
        chk("copy_ticks_lat1", gen[0].last_copy, N + 1);
        chk("copy_ticks_lat2", gen[1].last_copy, N + 2);
        chk("basic_end_lat1", {gen[0].busrq_n, gen[0].busy}, 2'b10);
        chk("basic_end_lat2", {gen[1].busrq_n, gen[1].busy}, 2'b10);

        // Late acknowledge: nothing may move while the grant is withheld.
        fill(1);
        hold = 1'b1;
        b0 = gen[0].nw; b1 = gen[1].nw;
        trigger();
        bad = 0;
        begin
            int t0 = tick;
            while (tick < t0 + 50) begin
                @(negedge clk);
                if (gen[0].src_cs | gen[1].src_cs | gen[0].obj_we | gen[1].obj_we) bad++;
            end
        end
        chk("late_wait_activity", bad, 0);
        chk("late_wait_writes", (gen[0].nw - b0) + (gen[1].nw - b1), 0);
        chk("late_wait_busrq", {gen[0].busrq_n, gen[1].busrq_n}, 2'b00);
        hold = 1'b0;
        wait_idle("late");
        chk("late_writes_lat1", gen[0].nw - b0, N);
        chk("late_writes_lat2", gen[1].nw - b1, N);

        // Mid-copy stall of 10 ticks.
        fill(1);
        b0 = gen[0].nw; b1 = gen[1].nw;
        trigger();
        wait_nw("stall", b0 + 100);
        hold = 1'b1;
        wait_ticks(10);
        hold = 1'b0;
        wait_idle("stall");
        chk("stall_writes_lat1", gen[0].nw - b0, N);
        chk("stall_writes_lat2", gen[1].nw - b1, N);

        // Retrigger during a copy, plus a merged extra edge.
        fill(1);
        b0 = gen[0].nw; b1 = gen[1].nw;
        trigger();
        wait_nw("retrig", b0 + 300);
        push_copy();
        @(negedge clk) dma_go = 1'b1;
        repeat (2) @(negedge clk);
        dma_go = 1'b0;
        repeat (2) @(negedge clk);
        dma_go = 1'b1;
        repeat (2) @(negedge clk);
        dma_go = 1'b0;
        wait_idle("retrig");
        chk("retrig_writes_lat1", gen[0].nw - b0, 2 * N);
        chk("retrig_writes_lat2", gen[1].nw - b1, 2 * N);
        chk("retrig_gap_lat1", gen[0].last_gap, 1);
        chk("retrig_gap_lat2", gen[1].last_gap, 1);

        // Reset in the middle of a copy, then a clean full copy.
        fill(1);
        b0 = gen[0].nw;
        trigger();
        wait_nw("rstmid", b0 + 200);
        @(negedge clk) rst = 1'b1;
        #1;
        check_rst("reset_mid_copy");
        gen[0].q.delete();
        gen[1].q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        b0 = gen[0].nw; b1 = gen[1].nw;
        trigger();
        wait_idle("after_rst");
        chk("after_rst_writes_lat1", gen[0].nw - b0, N);
        chk("after_rst_writes_lat2", gen[1].nw - b1, N);
        chk("after_rst_copy_ticks_lat1", gen[0].last_copy, N + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
